bitwise_alu_arbiter: RTL and testbench

Shares one W-bit bitwise logic unit (AND/ORR/EOR, optional BIC) between two requesters using round-robin arbitration with valid/ready handshakes. It sits between the two issue ports and the bitwise datapath. It registers each result together with its N/Z flags in a single-entry output buffer. It also keeps the architectural N/Z flag register, updated by flag-setting operations.

---
 rtl/bitwise_alu_arbiter.sv | 153 +++++++++++++++
 tb/tb_bitwise_alu_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_alu_arbiter
// Brief    : Round-robin sharing of one W-bit AND/ORR/EOR(/BIC) unit between
//            two requesters, single-entry response buffer, N/Z flag register.
//            Optional feature macro: BWALU_ARB_BIC_EN (op 3 = BIC when defined)
// Revision : 1.0
// ============================================================================
module bitwise_alu_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic         req0_s,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic         req1_s,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_o,
    output logic         rsp_n,
    output logic         rsp_z,
    output logic         rsp_err,
    output logic         flag_n,
    output logic         flag_z
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]   r_state;
    logic [0:0]   w_state_next;
    logic         r_last;
    logic         r_id;
    logic [W-1:0] r_o;
    logic         r_n;
    logic         r_z;
    logic         r_err;
    logic         r_flag_n;
    logic         r_flag_z;

    logic         w_space;
    logic         w_grant;
    logic         w_xfer;
    logic [1:0]   w_op;
    logic         w_s;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_res;
    logic         w_err;
    logic         w_n;
    logic         w_z;

    assign rsp_valid = (r_state == S_FULL);
    assign w_space   = ~rsp_valid | rsp_ready;

    // On conflict, favour the requester that was not granted last.
    always_comb begin
        w_grant = req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last;
        end
    end

    assign req0_ready = ~w_grant & w_space;
    assign req1_ready =  w_grant & w_space;
    assign w_xfer     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign w_op = w_grant ? req1_op : req0_op;
    assign w_s  = w_grant ? req1_s  : req0_s;
    assign w_a  = w_grant ? req1_a  : req0_a;
    assign w_b  = w_grant ? req1_b  : req0_b;

    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (w_op)
            2'd0:    w_res = w_a & w_b;
            2'd1:    w_res = w_a | w_b;
            2'd2:    w_res = w_a ^ w_b;
            default: begin
`ifdef BWALU_ARB_BIC_EN
                w_res = w_a & ~w_b;
`else
                w_err = 1'b1;
`endif
            end
        endcase
    end

    assign w_n = w_res[W-1];
    assign w_z = ~|w_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_xfer) w_state_next = S_FULL;
            S_FULL:  if (rsp_ready && !w_xfer) w_state_next = S_EMPTY;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_o      <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_err    <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
        end else if (w_xfer) begin
            r_last <= w_grant;
            r_id   <= w_grant;
            r_o    <= w_res;
            r_n    <= w_n;
            r_z    <= w_z;
            r_err  <= w_err;
            if (w_s && !w_err) begin
                r_flag_n <= w_n;
                r_flag_z <= w_z;
            end
        end
    end

    assign rsp_id  = r_id;
    assign rsp_o   = r_o;
    assign rsp_n   = r_n;
    assign rsp_z   = r_z;
    assign rsp_err = r_err;
    assign flag_n  = r_flag_n;
    assign flag_z  = r_flag_z;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitwise_alu_arbiter
// Brief    : Scoreboard bench for bitwise_alu_arbiter (honours BWALU_ARB_BIC_EN)
// Revision : 1.0
// ============================================================================
module tb_bitwise_alu_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_s;
    logic [1:0]   req0_op;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_s;
    logic [1:0]   req1_op;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_n, rsp_z, rsp_err;
    logic [W-1:0] rsp_o;
    logic         flag_n, flag_z;
    logic [W+4:0] rsp_vec;

    // Scoreboard entry: {valid, id, err, n, z, o}
    logic [W+4:0] sb[$];
    logic         m_last, m_fn, m_fz, m_space, m_grant, m_rdy0, m_rdy1;
    int           n_chk, n_fail;

    assign rsp_vec = {rsp_valid, rsp_id, rsp_err, rsp_n, rsp_z, rsp_o};

    bitwise_alu_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_s(req0_s), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_s(req1_s), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_o(rsp_o), .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_err(rsp_err),
        .flag_n(flag_n), .flag_z(flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {err, n, z, o}
    function automatic logic [W+2:0] calc(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] o;
        logic         e;
        e = 1'b0;
        case (op)
            2'd0:    o = a & b;
            2'd1:    o = a | b;
            2'd2:    o = a ^ b;
            default: begin
`ifdef BWALU_ARB_BIC_EN
                o = a & ~b;
`else
                o = '0;
                e = 1'b1;
`endif
            end
        endcase
        return {e, o[W-1], (o == '0), o};
    endfunction

    task automatic set_req(input int idx, input logic v, input logic [1:0] op, input logic s,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (idx == 0) begin
            req0_valid = v; req0_op = op; req0_s = s; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_s = s; req1_a = a; req1_b = b;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_last = 1'b1;
        m_fn   = 1'b0;
        m_fz   = 1'b0;
    endtask

    // Let inputs settle, then predict space/grant/readies.
    task automatic prep();
        #1;
        m_space = (sb.size() == 0) | rsp_ready;
        m_grant = (req0_valid & req1_valid) ? ~m_last : req1_valid;
        m_rdy0  = ~m_grant & m_space;
        m_rdy1  =  m_grant & m_space;
    endtask

    // Commit the predicted transfer/consumption, clock, and step past the edge.
    task automatic step();
        logic         t, s;
        logic [1:0]   op;
        logic [W-1:0] a, b;
        logic [W+2:0] r;
        logic [W+4:0] junk;
        t = (req0_valid & m_rdy0) | (req1_valid & m_rdy1);
        if (sb.size() != 0 && rsp_ready) junk = sb.pop_front();
        if (t) begin
            op = m_grant ? req1_op : req0_op;
            s  = m_grant ? req1_s  : req0_s;
            a  = m_grant ? req1_a  : req0_a;
            b  = m_grant ? req1_b  : req0_b;
            r  = calc(op, a, b);
            sb.push_back({1'b1, m_grant, r});
            if (s && !r[W+2]) begin
                m_fn = r[W+1];
                m_fz = r[W];
            end
            m_last = m_grant;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 2'd0, 1'b0, '0, '0);
        set_req(1, 1'b0, 2'd0, 1'b0, '0, '0);
        model_reset();
        #3;
        n_chk++;
        if ({rsp_vec, flag_n, flag_z} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h expected 0", {rsp_vec, flag_n, flag_z});
        end
        n_chk++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_conflict();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 2'd0, 1'b0, 32'h1234_5678, 32'h0000_FFFF);
        set_req(1, 1'b1, 2'd1, 1'b0, 32'h8000_0000, 32'h0000_0001);
        for (int i = 0; i < 4; i++) begin
            prep();
            n_chk++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL conflict_ready[%0d]: got %b", i, {req0_ready, req1_ready});
            end
            step();
            n_chk++;
            if (sb.size() == 0 || rsp_vec !== sb[0] || rsp_id !== i[0]) begin
                n_fail++;
                $display("FAIL conflict_rsp[%0d]: got %h expected %h", i, rsp_vec, sb.size() != 0 ? sb[0] : '0);
            end
        end
        set_req(0, 1'b0, 2'd0, 1'b0, '0, '0);
        set_req(1, 1'b0, 2'd0, 1'b0, '0, '0);
        prep();
        step();
        n_chk++;
        if (rsp_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL conflict_drain: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_single_op();
        set_req(0, 1'b1, 2'd2, 1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F);
        prep();
        step();
        req0_valid = 1'b0;
        n_chk++;
        if (sb.size() == 0 || rsp_vec !== sb[0]) begin
            n_fail++;
            $display("FAIL eor_rsp: got %h expected %h", rsp_vec, sb.size() != 0 ? sb[0] : '0);
        end
        n_chk++;
        if ({rsp_valid, rsp_id, rsp_o, rsp_n, rsp_z, flag_n, flag_z} !== {2'b10, 32'hF0F0_0F0F, 4'b1010}) begin
            n_fail++;
            $display("FAIL eor_values: got o=%h n=%b z=%b fn=%b fz=%b expected o=f0f00f0f n=1 z=0 fn=1 fz=0",
                     rsp_o, rsp_n, rsp_z, flag_n, flag_z);
        end
    endtask

    task automatic test_zero_result();
        set_req(1, 1'b1, 2'd0, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
        prep();
        step();
        n_chk++;
        if (sb.size() == 0 || rsp_vec !== sb[0] || rsp_o !== '0 || rsp_z !== 1'b1 || flag_z !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_rsp: got %h fz=%b expected %h fz=1", rsp_vec, flag_z, sb.size() != 0 ? sb[0] : '0);
        end
        set_req(1, 1'b1, 2'd1, 1'b0, 32'h1, 32'h1);
        prep();
        step();
        set_req(1, 1'b0, 2'd0, 1'b0, '0, '0);
        n_chk++;
        if (sb.size() == 0 || rsp_vec !== sb[0] || rsp_o !== 32'h1 || {flag_n, flag_z} !== {m_fn, m_fz} || flag_z !== 1'b1) begin
            n_fail++;
            $display("FAIL noflag_rsp: got %h flags=%b%b expected o=1 flags=%b%b", rsp_vec, flag_n, flag_z, m_fn, m_fz);
        end
        prep();
        step();
    endtask

    task automatic test_backpressure();
        logic [W+4:0] held;
        set_req(0, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0000_FFFF);
        set_req(1, 1'b1, 2'd1, 1'b1, 32'h0101_0101, 32'h1010_1010);
        prep();
        step();
        held = sb[0];
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            prep();
            n_chk++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got %b expected 00", i, {req0_ready, req1_ready});
            end
            step();
            n_chk++;
            if (rsp_vec !== held) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %h expected %h", i, rsp_vec, held);
            end
        end
        rsp_ready = 1'b1;
        prep();
        step();
        n_chk++;
        if (sb.size() != 1 || rsp_vec !== sb[0] || rsp_id === held[W+3]) begin
            n_fail++;
            $display("FAIL bp_release: got %h expected %h", rsp_vec, sb.size() != 0 ? sb[0] : '0);
        end
        n_chk++;
        if ({flag_n, flag_z} !== {m_fn, m_fz}) begin
            n_fail++;
            $display("FAIL bp_flags: got %b%b expected %b%b", flag_n, flag_z, m_fn, m_fz);
        end
        set_req(0, 1'b0, 2'd0, 1'b0, '0, '0);
        set_req(1, 1'b0, 2'd0, 1'b0, '0, '0);
        prep();
        step();
    endtask

    task automatic test_op3();
        logic pfn, pfz;
        pfn = m_fn;
        pfz = m_fz;
        set_req(0, 1'b1, 2'd3, 1'b1, 32'hFF, 32'h0F);
        prep();
        step();
        req0_valid = 1'b0;
        n_chk++;
        if (sb.size() == 0 || rsp_vec !== sb[0]) begin
            n_fail++;
            $display("FAIL op3_rsp: got %h expected %h", rsp_vec, sb.size() != 0 ? sb[0] : '0);
        end
        n_chk++;
`ifdef BWALU_ARB_BIC_EN
        if ({rsp_err, rsp_o, flag_n, flag_z} !== {1'b0, 32'hF0, 2'b00}) begin
            n_fail++;
            $display("FAIL op3_bic: got err=%b o=%h flags=%b%b expected err=0 o=f0 flags=00", rsp_err, rsp_o, flag_n, flag_z);
        end
`else
        if ({rsp_err, rsp_o, rsp_n, rsp_z, flag_n, flag_z} !== {1'b1, 32'h0, 2'b01, pfn, pfz}) begin
            n_fail++;
            $display("FAIL op3_illegal: got err=%b o=%h n=%b z=%b flags=%b%b expected err=1 o=0 n=0 z=1 flags=%b%b",
                     rsp_err, rsp_o, rsp_n, rsp_z, flag_n, flag_z, pfn, pfz);
        end
`endif
        prep();
        step();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 2'd2, 1'b1, 32'h8000_0000, 32'h0);
        prep();
        step();
        req0_valid = 1'b0;
        n_chk++;
        if (sb.size() == 0 || rsp_vec !== sb[0] || {flag_n, flag_z} !== 2'b10) begin
            n_fail++;
            $display("FAIL pre_reset_full: got %h flags=%b%b expected %h flags=10", rsp_vec, flag_n, flag_z, sb.size() != 0 ? sb[0] : '0);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if ({rsp_valid, flag_n, flag_z} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b flags=%b%b expected 000", rsp_valid, flag_n, flag_z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 2'd1, 1'b0, 32'h3, 32'h4);
        set_req(1, 1'b1, 2'd0, 1'b0, 32'h3, 32'h4);
        prep();
        n_chk++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        step();
        n_chk++;
        if (sb.size() == 0 || rsp_vec !== sb[0] || rsp_id !== 1'b0 || rsp_o !== 32'h7) begin
            n_fail++;
            $display("FAIL post_reset_rsp: got %h expected %h", rsp_vec, sb.size() != 0 ? sb[0] : '0);
        end
        set_req(0, 1'b0, 2'd0, 1'b0, '0, '0);
        set_req(1, 1'b0, 2'd0, 1'b0, '0, '0);
        prep();
        step();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_conflict();
        test_single_op();
        test_zero_result();
        test_backpressure();
        test_op3();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
